// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART FIFO controller: default geometry,
// requester indices and UART status register bit positions.
package uart_fifo_pkg;

  localparam int unsigned FIFO_D  = 8;
  localparam int unsigned FIFO_A  = 3;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ_RX  = 0;
  localparam int unsigned REQ_LB  = 1;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_AE    = 2;
  localparam int unsigned ST_AF    = 3;
  localparam int unsigned ST_OVF   = 4;
  localparam int unsigned ST_UDF   = 5;
  localparam int unsigned ST_W     = 6;

  typedef enum logic {
    PRIO_RX = 1'b0,
    PRIO_LB = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; priority flips to the other requester
// only when adv_i reports that a grant was actually accepted.
module rr_arb2
  import uart_fifo_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output prio_e              prio_o
);

  prio_e prio_q;
  prio_e prio_d;

  // Grant selection; a lone requester always wins regardless of priority
  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (req_i[REQ_RX] && (!req_i[REQ_LB] || (prio_q == PRIO_RX))) begin
        gnt_o[REQ_RX] = 1'b1;
      end else if (req_i[REQ_LB]) begin
        gnt_o[REQ_LB] = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (adv_i) begin
      prio_d = gnt_o[REQ_RX] ? PRIO_LB : PRIO_RX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= PRIO_RX;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/fifo_ctrl_arb.sv
// UART FIFO controller: pointer management, two-port write arbitration,
// occupancy/threshold flags and sticky overflow/underflow status.
module fifo_ctrl_arb
  import uart_fifo_pkg::*;
#(
  parameter int unsigned D      = FIFO_D,
  parameter int unsigned A      = FIFO_A,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 1
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         req0,
  input  logic         req1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         wsel,
  output logic         winc,
  output logic         wfull,
  output logic [A-1:0] waddr,
  output logic [A-1:0] raddr,
  input  logic         rd_en,
  output logic         rd_ack,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [A:0]   count,
  output logic         ovf,
  output logic         udf,
  input  logic         clr_err
);

  localparam int unsigned PW = A + 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               wsel_q, wsel_d;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               full_w;
  logic               empty_w;
  logic               accept_w;
  logic               pop_w;
  prio_e              prio_unused;

  // Status is derived only from registered pointers
  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[A] != rptr_q[A]) && (wptr_q[A-1:0] == rptr_q[A-1:0]);
  assign count   = wptr_q - rptr_q;

  assign req[REQ_RX] = req0;
  assign req[REQ_LB] = req1;

  rr_arb2 u_arb (
    .clk_i  (wclk),
    .rst_i  (wrst),
    .req_i  (req),
    .en_i   (!full_w),
    .adv_i  (accept_w),
    .gnt_o  (gnt),
    .prio_o (prio_unused)
  );

  assign accept_w = |gnt;
  assign pop_w    = rd_en & !empty_w;

  // Next-state for pointers, mux select and sticky errors (set beats clear)
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wsel_d = wsel_q;
    ovf_d  = ovf_q & !clr_err;
    udf_d  = udf_q & !clr_err;
    if (accept_w) begin
      wptr_d = wptr_q + PW'(1);
      wsel_d = gnt[REQ_LB];
    end
    if (pop_w) begin
      rptr_d = rptr_q + PW'(1);
    end
    if ((req0 | req1) & full_w) begin
      ovf_d = 1'b1;
    end
    if (rd_en & empty_w) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wsel_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wsel_q <= wsel_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign gnt0         = gnt[REQ_RX];
  assign gnt1         = gnt[REQ_LB];
  assign wsel         = wsel_d;
  assign winc         = accept_w;
  assign wfull        = full_w;
  assign waddr        = wptr_q[A-1:0];
  assign raddr        = rptr_q[A-1:0];
  assign rd_ack       = pop_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count >= PW'(AF_LVL));
  assign almost_empty = (count <= PW'(AE_LVL));
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Directed self-checking bench for fifo_ctrl_arb with a small memory model.
module tb_fifo_ctrl_arb;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic       gnt0, gnt1, wsel, winc, wfull, rd_ack;
  logic       full, empty, almost_full, almost_empty, ovf, udf;
  logic [2:0] waddr, raddr;
  logic [3:0] count;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [7:0] mem [8];
  logic [7:0] q [$];
  logic [6:0] wcnt = '0;
  logic [7:0] wdat;

  always #5 wclk = ~wclk;

  fifo_ctrl_arb #(.D(8), .A(3), .AF_LVL(6), .AE_LVL(1)) dut (
    .wclk(wclk), .wrst(wrst), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .wsel(wsel), .winc(winc), .wfull(wfull),
    .waddr(waddr), .raddr(raddr), .rd_en(rd_en), .rd_ack(rd_ack),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .ovf(ovf), .udf(udf),
    .clr_err(clr_err)
  );

  // External memory plus expected-order scoreboard
  assign wdat = {wsel, wcnt};
  always @(posedge wclk) begin
    if (wrst) begin
      q.delete();
    end else begin
      if (rd_ack && q.size() > 0) q.delete(0);
      if (winc) begin
        mem[waddr] <= wdat;
        q.push_back(wdat);
        wcnt <= wcnt + 7'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop();
    logic [31:0] exp;
    exp = (q.size() > 0) ? {24'd0, q[0]} : 32'hdead;
    chk("rd_ack", 32'(rd_ack), 32'd1);
    chk("rdata", {24'd0, mem[raddr]}, exp);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    wrst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);

    // Fill with requester 0 only
    req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_gnt0", 32'(gnt0), 1);
      chk("fill_waddr", 32'(waddr), 32'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("full_flag", 32'(full), 1);
    chk("full_wfull", 32'(wfull), 1);
    chk("full_count", 32'(count), 8);
    chk("full_gnt0", 32'(gnt0), 0);
    chk("full_winc", 32'(winc), 0);
    chk("full_ovf_pre", 32'(ovf), 0);
    tick();
    req0 = 1'b0;
    #1;
    chk("ovf_set", 32'(ovf), 1);

    // Both requesters from reset alternate
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", 32'(gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_wsel", 32'(wsel), 32'(i % 2));
      tick();
    end
    req1 = 1'b0;
    #1;
    chk("rr_count", 32'(count), 4);
    chk("rr_wsel_hold", 32'(wsel), 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("top_gnt0", 32'(gnt0), 1);
      tick();
    end
    req0 = 1'b0;
    #1;
    chk("refull", 32'(full), 1);
    chk("wsel_idle_hold", 32'(wsel), 0);

    // Full with write and pop together
    req1 = 1'b1;
    rd_en = 1'b1;
    #1;
    chk("fp_gnt1", 32'(gnt1), 0);
    chk_pop();
    tick();
    req1 = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("fp_count", 32'(count), 7);
    chk("fp_ovf", 32'(ovf), 1);
    chk("fp_full", 32'(full), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("ovf_clr", 32'(ovf), 0);

    // Streaming through the pointer wrap
    req0 = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("wr_raddr", 32'(raddr), 32'((i + 1) % 8));
      chk("wr_gnt0", 32'(gnt0), 1);
      chk("wr_count", 32'(count), 7);
      chk_pop();
      tick();
    end
    req0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk_pop();
      tick();
    end
    rd_en = 1'b0;
    #1;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    chk("drain_udf", 32'(udf), 0);

    // Empty with write and pop together
    rd_en = 1'b1;
    req0 = 1'b1;
    #1;
    chk("ep_rd_ack", 32'(rd_ack), 0);
    chk("ep_gnt0", 32'(gnt0), 1);
    tick();
    rd_en = 1'b0;
    req0 = 1'b0;
    #1;
    chk("ep_udf", 32'(udf), 1);
    chk("ep_count", 32'(count), 1);
    chk("ep_empty", 32'(empty), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("udf_clr", 32'(udf), 0);
    rd_en = 1'b1;
    #1;
    chk_pop();
    tick();
    clr_err = 1'b1;
    #1;
    chk("setwin_rd_ack", 32'(rd_ack), 0);
    tick();
    rd_en = 1'b0;
    clr_err = 1'b0;
    #1;
    chk("udf_set_wins", 32'(udf), 1);
    chk("setwin_empty", 32'(empty), 1);

    // Reset mid-traffic restores priority to requester 0
    req0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req1 = 1'b1;
    #1;
    chk("mid_count", 32'(count), 5);
    chk("mid_gnt1_prio", 32'(gnt1), 1);
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_udf", 32'(udf), 0);
    chk("mrst_gnt0", 32'(gnt0), 1);
    chk("mrst_gnt1", 32'(gnt1), 0);
    tick();
    #1;
    chk("mrst_next_gnt1", 32'(gnt1), 1);
    chk("mrst_next_count", 32'(count), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_arb.md
Name: fifo_ctrl_arb

Overview:
Single-clock controller for the UART FIFO memory. It owns the write and read pointers and generates waddr, raddr, winc and wfull for the memory. It round-robin arbitrates two write requesters: port 0 is the RX deserializer and port 1 is the host loopback/inject path. It also produces occupancy, threshold and sticky error status for the UART control registers.

Parameters:
D, 8, FIFO depth in words; must equal 2**A
A, 3, address width
AF_LVL, 6, almost_full asserted when count >= AF_LVL
AE_LVL, 1, almost_empty asserted when count <= AE_LVL

Ports:
wclk  in  1  clock
wrst  in  1  reset, synchronous, active-high
req0  in  1  write request, requester 0 (RX)
req1  in  1  write request, requester 1 (loopback)
gnt0  out  1  requester 0 write accepted this cycle
gnt1  out  1  requester 1 write accepted this cycle
wsel  out  1  wdata mux select for the memory; 0=req0 data, 1=req1 data
winc  out  1  memory write strobe; equals gnt0|gnt1
wfull  out  1  memory write block; equals full
waddr  out  A  memory write address
raddr  out  A  memory read address; memory rdata is valid combinationally when !empty
rd_en  in  1  pop request from TX/host side
rd_ack  out  1  pop accepted this cycle
full  out  1  FIFO full
empty  out  1  FIFO empty
almost_full  out  1  count >= AF_LVL
almost_empty  out  1  count <= AE_LVL
count  out  A+1  occupancy, 0..D
ovf  out  1  sticky overflow: write requested while full
udf  out  1  sticky underflow: pop requested while empty
clr_err  in  1  clears ovf and udf

Behaviour:
- Reset (wrst=1 at posedge wclk) sets: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, ovf=0, udf=0, round-robin priority pointer=req0. Reset overrides all other inputs in the same cycle. Reset mid-transfer discards the FIFO contents; memory contents are not cleared by this block.
- Pointers are A+1 bits. waddr=wptr[A-1:0], raddr=rptr[A-1:0].
- empty = (wptr==rptr). full = MSBs differ and low A bits equal. count = wptr-rptr, modulo 2**(A+1). All are registered or derived purely from registered pointers; no combinational path from req/rd_en.
- Arbitration is combinational within the cycle and evaluated against the current full:
  - If full, both grants are 0.
  - If only one req is high, grant it.
  - If both are high, grant the requester holding priority.
  - The priority pointer moves to the other requester only after an accepted grant.
  - wsel = 1 iff gnt1; when there is no grant, wsel holds its last value.
- Write accept: winc=1, and wptr increments at the next edge. Pointers wrap naturally at 2**(A+1).
- Pop accept: rd_ack = rd_en & !empty, and rptr increments at the next edge. Data at raddr is presented in the same cycle as rd_ack.
- Simultaneous write and pop:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: pop is accepted, write is rejected, count goes to D-1.
  - Empty: write is accepted, pop is rejected, count goes to 1. There is no fall-through.
- ovf sets at the edge where (req0|req1)&full. udf sets at the edge where rd_en&empty. Both hold until clr_err or reset. If clr_err and a new error event occur in the same cycle, the flag stays set (set wins).
- Latency: accepted write is visible as !empty one cycle later; accepted pop updates full/count one cycle later.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - default depth/address constants (D, A);
  - the requester index constants REQ_RX=0 and REQ_LB=1;
  - the status bit-position constants used by the UART status register.
- One sub-module: rr_arb2, the two-input round-robin arbiter with a priority register and an advance-on-accept input.
- Pointer, flag and status logic stays in the top module.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, almost_empty=1, gnt0=gnt1=0, ovf=udf=0.
- req0 held for 8 cycles (D=8) → gnt0 on each cycle, waddr 0..7, full=1 after the 8th edge, count=8, almost_full first asserts when count=6. A 9th req0 gives gnt0=0 and ovf=1 next edge.
- req0 and req1 both held high for 4 cycles from reset → grants alternate gnt0,gnt1,gnt0,gnt1; wsel=0,1,0,1; count=4.
- FIFO full with req1 and rd_en high in the same cycle → rd_ack=1, gnt1=0, count=7, ovf=1. Wrap check: fill/drain 12 words → raddr wraps 7→0, and data order is preserved against the memory model.
- Empty with rd_en and req0 in the same cycle → rd_ack=0, gnt0=1, udf=1, count=1. Then clr_err pulse → udf=0. clr_err together with a new rd_en while empty → udf stays 1.
- wrst asserted with count=5 mid-traffic → next edge count=0, empty=1, priority returns to req0 (both reqs high → gnt0 first).
